// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-port BRAM arbiter:
//   - ADDR_W / DATA_W : default memory address / data widths (256x16 BRAM)
//   - state_e         : arbiter FSM state encoding
//   - PORT0 / PORT1   : requester identifiers (CPU path / loader-debug path)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational winner selection between two requesters.
//   req0_i, req1_i  : pending requests
//   last_i          : port granted most recently (round-robin pointer)
//   lock_valid_i    : a lock is held
//   lock_id_i       : port owning the lock
//   grant_valid_o   : some port wins this cycle
//   grant_id_o      : winning port
// A held lock only binds while its owner is still requesting; once the owner
// lets go, plain round-robin applies in the same cycle.
// -----------------------------------------------------------------------------
module rr_pick2
   import mem_arbiter_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   input  logic lock_valid_i,
   input  logic lock_id_i,
   output logic grant_valid_o,
   output logic grant_id_o
);

   logic owner_req_s;

   assign owner_req_s = (lock_id_i == PORT1) ? req1_i : req0_i;

   // Winner selection: lock owner first, then round-robin on a tie
   always_comb begin
      grant_valid_o = 1'b0;
      grant_id_o    = PORT0;
      if (lock_valid_i && owner_req_s) begin
         grant_valid_o = 1'b1;
         grant_id_o    = lock_id_i;
      end else if (req0_i && req1_i) begin
         grant_valid_o = 1'b1;
         grant_id_o    = ~last_i;
      end else if (req0_i) begin
         grant_valid_o = 1'b1;
         grant_id_o    = PORT0;
      end else if (req1_i) begin
         grant_valid_o = 1'b1;
         grant_id_o    = PORT1;
      end else begin
         grant_valid_o = 1'b0;
         grant_id_o    = PORT0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single port of a 256x16 BRAM between two Req/Ack requesters.
// Each access takes IDLE (arbitrate) -> ACCESS (memory enabled for one cycle,
// memory acts on the negedge inside it) -> RESP (Ack pulse).
//   Clk, Reset              : clock, asynchronous active-high reset
//   Req/Wr/Lock/Addr/WData  : per-port request inputs (0 = CPU, 1 = loader)
//   Ack/RData               : per-port completion pulse and last read data
//   Mem_Addr/Mem_DIn        : memory address / write data (held between uses)
//   Mem_DOut                : memory read data
//   Mem_En/Mem_Write_EN     : active-low memory controls
//   Busy                    : FSM not in IDLE
// All outputs come straight from registers so the memory sees controls that
// only move on posedges and are stable across its sampling negedge.
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AddrWidth = ADDR_W,
   parameter int DataWidth = DATA_W
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Req0,
   input  logic                 Req1,
   input  logic                 Wr0,
   input  logic                 Wr1,
   input  logic                 Lock0,
   input  logic                 Lock1,
   input  logic [AddrWidth-1:0] Addr0,
   input  logic [AddrWidth-1:0] Addr1,
   input  logic [DataWidth-1:0] WData0,
   input  logic [DataWidth-1:0] WData1,
   output logic                 Ack0,
   output logic                 Ack1,
   output logic [DataWidth-1:0] RData0,
   output logic [DataWidth-1:0] RData1,
   output logic [AddrWidth-1:0] Mem_Addr,
   output logic [DataWidth-1:0] Mem_DIn,
   input  logic [DataWidth-1:0] Mem_DOut,
   output logic                 Mem_En,
   output logic                 Mem_Write_EN,
   output logic                 Busy
);

   state_e state_q, state_d;

   logic                 last_q, last_d;
   logic                 gnt_q, gnt_d;
   logic                 lock_valid_q, lock_valid_d;
   logic                 lock_id_q, lock_id_d;
   logic                 mem_en_q, mem_en_d;
   logic                 mem_we_q, mem_we_d;
   logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
   logic [DataWidth-1:0] mem_din_q, mem_din_d;
   logic                 ack0_q, ack0_d;
   logic                 ack1_q, ack1_d;
   logic [DataWidth-1:0] rdata0_q, rdata0_d;
   logic [DataWidth-1:0] rdata1_q, rdata1_d;
   logic                 busy_q, busy_d;

   logic                 grant_valid_s;
   logic                 grant_id_s;
   logic                 lock_drop_s;
   logic                 win_wr_s;
   logic [AddrWidth-1:0] win_addr_s;
   logic [DataWidth-1:0] win_data_s;
   logic                 gnt_lock_s;

   rr_pick2 u_pick (
      .req0_i        (Req0),
      .req1_i        (Req1),
      .last_i        (last_q),
      .lock_valid_i  (lock_valid_q),
      .lock_id_i     (lock_id_q),
      .grant_valid_o (grant_valid_s),
      .grant_id_o    (grant_id_s)
   );

   // The lock evaporates as soon as its owner stops requesting in IDLE
   assign lock_drop_s = lock_valid_q && !((lock_id_q == PORT1) ? Req1 : Req0);
   assign win_wr_s    = (grant_id_s == PORT1) ? Wr1    : Wr0;
   assign win_addr_s  = (grant_id_s == PORT1) ? Addr1  : Addr0;
   assign win_data_s  = (grant_id_s == PORT1) ? WData1 : WData0;
   assign gnt_lock_s  = (gnt_q == PORT1)      ? Lock1  : Lock0;

   // FSM state register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid_s) begin
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values, registered below
   always_comb begin
      mem_en_d     = 1'b1;
      mem_we_d     = 1'b1;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      last_d       = last_q;
      gnt_d        = gnt_q;
      lock_valid_d = lock_valid_q;
      lock_id_d    = lock_id_q;
      busy_d       = (state_d != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (lock_drop_s) begin
               lock_valid_d = 1'b0;
            end else begin
               lock_valid_d = lock_valid_q;
            end
            if (grant_valid_s) begin
               gnt_d      = grant_id_s;
               last_d     = grant_id_s;
               mem_en_d   = 1'b0;
               mem_we_d   = ~win_wr_s;
               mem_addr_d = win_addr_s;
               mem_din_d  = win_data_s;
            end else begin
               mem_en_d   = 1'b1;
            end
         end
         ST_ACCESS: begin
            ack0_d       = (gnt_q == PORT0);
            ack1_d       = (gnt_q == PORT1);
            lock_valid_d = gnt_lock_s;
            lock_id_d    = gnt_q;
            // mem_we_q high means this access was a read
            if (mem_we_q) begin
               if (gnt_q == PORT1) begin
                  rdata1_d = Mem_DOut;
               end else begin
                  rdata0_d = Mem_DOut;
               end
            end else begin
               rdata0_d = rdata0_q;
            end
         end
         ST_RESP: begin
            ack0_d = 1'b0;
            ack1_d = 1'b0;
         end
         default: begin
            mem_en_d = 1'b1;
         end
      endcase
   end

   // Output and bookkeeping registers; reset forces the memory disabled at once
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mem_en_q     <= 1'b1;
         mem_we_q     <= 1'b1;
         mem_addr_q   <= {AddrWidth{1'b0}};
         mem_din_q    <= {DataWidth{1'b0}};
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= {DataWidth{1'b0}};
         rdata1_q     <= {DataWidth{1'b0}};
         busy_q       <= 1'b0;
         last_q       <= PORT1;
         gnt_q        <= PORT0;
         lock_valid_q <= 1'b0;
         lock_id_q    <= PORT0;
      end else begin
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         busy_q       <= busy_d;
         last_q       <= last_d;
         gnt_q        <= gnt_d;
         lock_valid_q <= lock_valid_d;
         lock_id_q    <= lock_id_d;
      end
   end

   assign Mem_En       = mem_en_q;
   assign Mem_Write_EN = mem_we_q;
   assign Mem_Addr     = mem_addr_q;
   assign Mem_DIn      = mem_din_q;
   assign Ack0         = ack0_q;
   assign Ack1         = ack1_q;
   assign RData0       = rdata0_q;
   assign RData1       = rdata1_q;
   assign Busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two requester drivers feed planned transactions; a negedge monitor pairs
// each observed memory access and Ack with the oldest issued transaction of
// that port and checks it against a reference memory image.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          lock;
      int            gap;
      int            lat;   // >0 exact Ack latency, 0 bounded by 6, <0 unchecked
   } txn_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic          we_n;
      logic [DW-1:0] din;
   } acc_t;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          req_s   [2];
   logic          wr_s    [2];
   logic          lock_s  [2];
   logic [AW-1:0] addr_s  [2];
   logic [DW-1:0] wdata_s [2];
   logic          ack0, ack1, busy, mem_en, mem_we;
   logic [DW-1:0] rdata0, rdata1, mem_din;
   logic [DW-1:0] mem_dout = 16'h0000;
   logic [AW-1:0] mem_addr;

   logic [DW-1:0] mem     [256];
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] rdata_m [2];

   txn_t plan0[$], plan1[$], exp0[$], exp1[$];
   acc_t acc_q[$];
   int   grant_log[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ack_cnt = 0;

   mem_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .Req0(req_s[0]), .Req1(req_s[1]),
      .Wr0(wr_s[0]), .Wr1(wr_s[1]),
      .Lock0(lock_s[0]), .Lock1(lock_s[1]),
      .Addr0(addr_s[0]), .Addr1(addr_s[1]),
      .WData0(wdata_s[0]), .WData1(wdata_s[1]),
      .Ack0(ack0), .Ack1(ack1),
      .RData0(rdata0), .RData1(rdata1),
      .Mem_Addr(mem_addr), .Mem_DIn(mem_din), .Mem_DOut(mem_dout),
      .Mem_En(mem_en), .Mem_Write_EN(mem_we), .Busy(busy)
   );

   always #5 Clk = ~Clk;

   function automatic logic [DW-1:0] init_val(input int i);
      logic [DW-1:0] v;
      v = 16'(i * 40503) ^ 16'h5A5A;
      if (i == 5) v = 16'hBEEF;
      return v;
   endfunction

   function automatic txn_t mk(input logic wr, input int addr, input int data,
                               input logic lock, input int gap, input int lat);
      txn_t t;
      t.wr = wr; t.addr = 8'(addr); t.data = 16'(data);
      t.lock = lock; t.gap = gap; t.lat = lat;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // BRAM stand-in: acts on the negedge while enabled
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_val(i);
      forever begin
         @(negedge Clk);
         if (!mem_en) begin
            if (!mem_we) mem[mem_addr] = mem_din;
            else         mem_dout = mem[mem_addr];
         end
      end
   end

   task automatic score();
      txn_t t;
      acc_t a;
      int   p;
      int   pend;
      logic exp_we_n;
      chk("ack_overlap", {31'd0, ack0 & ack1}, 32'd0);
      chk("busy_in_resp", {31'd0, busy}, 32'd1);
      p = ack1 ? 1 : 0;
      grant_log.push_back(p);
      ack_cnt++;
      pend = (p == 0) ? exp0.size() : exp1.size();
      chk("ack_has_request", {31'd0, pend > 0}, 32'd1);
      if (pend == 0) return;
      t = (p == 0) ? exp0.pop_front() : exp1.pop_front();
      chk("one_access_per_ack", acc_q.size(), 32'd1);
      if (acc_q.size() == 0) return;
      a = acc_q.pop_front();
      acc_q.delete();
      exp_we_n = !t.wr;
      chk("access_addr", {24'd0, a.addr}, {24'd0, t.addr});
      chk("access_we_n", {31'd0, a.we_n}, {31'd0, exp_we_n});
      if (t.wr) begin
         chk("access_din", {16'd0, a.din}, {16'd0, t.data});
         ref_mem[t.addr] = t.data;
      end else begin
         rdata_m[p] = ref_mem[t.addr];
      end
      chk("rdata_granted", {16'd0, (p == 0) ? rdata0 : rdata1}, {16'd0, rdata_m[p]});
      chk("rdata_other",   {16'd0, (p == 0) ? rdata1 : rdata0}, {16'd0, rdata_m[1-p]});
   endtask

   // Monitor: log memory accesses and score each Ack, all on the negedge
   initial begin
      logic prev_en;
      prev_en = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      rdata_m[0] = 16'h0000;
      rdata_m[1] = 16'h0000;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            prev_en = 1'b1;
            rdata_m[0] = 16'h0000;
            rdata_m[1] = 16'h0000;
            acc_q.delete();
         end else begin
            if (!mem_en) begin
               chk("mem_en_one_cycle", {31'd0, prev_en}, 32'd1);
               chk("busy_in_access", {31'd0, busy}, 32'd1);
               acc_q.push_back('{addr: mem_addr, we_n: mem_we, din: mem_din});
            end
            if (!mem_we) chk("we_only_with_en", {31'd0, mem_en}, 32'd0);
            if (ack0 || ack1) score();
            prev_en = mem_en;
         end
      end
   end

   task automatic run_port(input int p);
      txn_t t;
      int   lat;
      logic got;
      while (((p == 0) ? plan0.size() : plan1.size()) > 0) begin
         t = (p == 0) ? plan0.pop_front() : plan1.pop_front();
         if (t.gap > 0) begin
            req_s[p] = 1'b0;
            lock_s[p] = 1'b0;
            repeat (t.gap) begin @(posedge Clk); #1; end
         end
         wr_s[p] = t.wr; addr_s[p] = t.addr; wdata_s[p] = t.data; lock_s[p] = t.lock;
         if (p == 0) exp0.push_back(t); else exp1.push_back(t);
         req_s[p] = 1'b1;
         lat = 0;
         got = 1'b0;
         while (!got && lat < 60) begin
            @(posedge Clk); #1;
            lat++;
            got = (p == 0) ? ack0 : ack1;
         end
         chk("ack_timeout", {31'd0, got}, 32'd1);
         if (got && t.lat > 0) chk("ack_latency_exact", lat, t.lat);
         if (got && t.lat == 0) chk("ack_latency_bound", {31'd0, lat <= 6}, 32'd1);
      end
      req_s[p] = 1'b0;
      lock_s[p] = 1'b0;
   endtask

   task automatic run_both();
      fork
         run_port(0);
         run_port(1);
      join
   endtask

   task automatic drain();
      repeat (4) @(posedge Clk);
      #1;
      chk("idle_not_busy", {31'd0, busy}, 32'd0);
      chk("no_outstanding", exp0.size() + exp1.size(), 32'd0);
   endtask

   task automatic check_reset_vals();
      chk("rst_mem_en",   {31'd0, mem_en}, 32'd1);
      chk("rst_mem_we",   {31'd0, mem_we}, 32'd1);
      chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_mem_din",  {16'd0, mem_din}, 32'd0);
      chk("rst_ack0",     {31'd0, ack0}, 32'd0);
      chk("rst_ack1",     {31'd0, ack1}, 32'd0);
      chk("rst_rdata0",   {16'd0, rdata0}, 32'd0);
      chk("rst_rdata1",   {16'd0, rdata1}, 32'd0);
      chk("rst_busy",     {31'd0, busy}, 32'd0);
   endtask

   task automatic apply_reset();
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      check_reset_vals();
      Reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_lock [4];
      int acks_before;
      logic [DW-1:0] old_val;
      exp_lock = '{1, 1, 0, 1};
      for (int p = 0; p < 2; p++) begin
         req_s[p] = 1'b0; wr_s[p] = 1'b0; lock_s[p] = 1'b0;
         addr_s[p] = 8'h00; wdata_s[p] = 16'h0000;
      end

      // Reset state
      repeat (2) @(posedge Clk);
      #1;
      check_reset_vals();
      Reset = 1'b0;
      repeat (2) @(posedge Clk);
      #1;

      // Single read of a preloaded word
      plan0.push_back(mk(1'b0, 8'h05, 0, 1'b0, 0, 2));
      run_both();
      drain();
      chk("single_read_rdata0", {16'd0, rdata0}, 32'h0000BEEF);
      chk("single_read_rdata1", {16'd0, rdata1}, 32'h00000000);

      // Write then read back on port 1
      plan1.push_back(mk(1'b1, 8'h80, 16'h1234, 1'b0, 0, 2));
      plan1.push_back(mk(1'b0, 8'h80, 0, 1'b0, 0, 3));
      run_both();
      drain();
      chk("wr_rd_rdata1", {16'd0, rdata1}, 32'h00001234);

      // Req held through RESP: back-to-back grants at T3
      plan0.push_back(mk(1'b0, 8'h80, 0, 1'b0, 0, 2));
      plan0.push_back(mk(1'b0, 8'h07, 0, 1'b0, 0, 3));
      plan0.push_back(mk(1'b0, 8'h05, 0, 1'b0, 0, 3));
      run_both();
      drain();

      // Contention after reset: strict alternation starting with port 0
      apply_reset();
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin
         plan0.push_back(mk(1'(i & 1), 8'h10 + 8'(i), 16'hA000 + 16'(i), 1'b0, 0, 0));
         plan1.push_back(mk(1'b0, 8'h10 + 8'(i), 0, 1'b0, 0, 0));
      end
      run_both();
      drain();
      chk("contention_count", grant_log.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < grant_log.size()) chk("contention_order", grant_log[i], i % 2);
      end

      // Lock: port 1 holds the grant over a pending port 0
      grant_log.delete();
      plan1.push_back(mk(1'b1, 8'h20, 16'h5555, 1'b1, 0, 2));
      plan1.push_back(mk(1'b0, 8'h20, 0, 1'b0, 0, 3));
      plan1.push_back(mk(1'b0, 8'h21, 0, 1'b0, 0, 0));
      plan0.push_back(mk(1'b0, 8'h20, 0, 1'b0, 1, -1));
      run_both();
      drain();
      chk("lock_count", grant_log.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < grant_log.size()) chk("lock_order", grant_log[i], exp_lock[i]);
      end

      // Randomized traffic, no locks
      for (int i = 0; i < 40; i++) begin
         plan0.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
                            1'b0, $urandom_range(0, 3), 0));
         plan1.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
                            1'b0, $urandom_range(0, 3), 0));
      end
      run_both();
      drain();

      // Reset between the ACCESS posedge and the memory negedge
      old_val = ref_mem[8'h33];
      acks_before = ack_cnt;
      wr_s[0] = 1'b1; addr_s[0] = 8'h33; wdata_s[0] = ~old_val; lock_s[0] = 1'b0;
      req_s[0] = 1'b1;
      @(posedge Clk); #1;
      chk("midwrite_access_entered", {31'd0, mem_en}, 32'd0);
      Reset = 1'b1;
      #1;
      chk("midwrite_en_forced_high", {31'd0, mem_en}, 32'd1);
      req_s[0] = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check_reset_vals();
      Reset = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
      chk("midwrite_no_ack", ack_cnt, acks_before);
      chk("midwrite_mem_kept", {16'd0, mem[8'h33]}, {16'd0, old_val});

      // Final memory image
      for (int i = 0; i < 256; i++) chk("mem_image", {16'd0, mem[i]}, {16'd0, ref_mem[i]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the single-port 256x16 BRAM `Memory`. It lets two requesters share the one memory port: port 0 is the CPU fetch/data path and port 1 is the loader/debug path. Each requester uses a Req/Ack handshake. The block drives the memory's active-low `Mem_En`/`Write_EN` controls and returns read data per port. It sits between the control matrix/loader and the memory instance.

## Interface
- `AddrWidth`, 8, memory address width
- `DataWidth`, 16, memory data width
- `Clk`  in  1  system clock; the arbiter acts on the posedge, the memory samples on the negedge
- `Reset`  in  1  asynchronous, active-high reset
- `Req0`, `Req1`  in  1  access request, held high until the matching Ack
- `Wr0`, `Wr1`  in  1  1 = write, 0 = read; stable while Req is high
- `Lock0`, `Lock1`  in  1  keep the grant for the next transaction (read-modify-write)
- `Addr0`, `Addr1`  in  AddrWidth  access address; stable while Req is high
- `WData0`, `WData1`  in  DataWidth  write data; stable while Req is high
- `Ack0`, `Ack1`  out  1  one-cycle completion pulse
- `RData0`, `RData1`  out  DataWidth  last read data returned to that port
- `Mem_Addr`  out  AddrWidth  connects to memory `Address`
- `Mem_DIn`  out  DataWidth  connects to memory `DIn`
- `Mem_DOut`  in  DataWidth  memory `DOut`
- `Mem_En`  out  1  memory enable, active low
- `Mem_Write_EN`  out  1  memory write enable, active low
- `Busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states:
  - IDLE: arbitrate. When a winner exists, go to ACCESS.
  - ACCESS: exactly one cycle with the memory enabled. Always go to RESP.
  - RESP: Ack cycle. Always go to IDLE.
- Arbitration in IDLE, round-robin on `last` (the port granted most recently):
  - Only one Req high: that port wins.
  - Both Req high: the port other than `last` wins.
  - `last` resets to 1, so port 0 wins the first tie.
- Lock:
  - `lock_owner` is set to the granted port if its Lock is high when sampled at the end of ACCESS. It is cleared if that Lock is low.
  - While `lock_owner` is valid, IDLE grants only the owner.
  - If the owner's Req is low in IDLE, the lock is cleared and normal arbitration runs in the same cycle.
- On entry to ACCESS, registered outputs take:
  - `Mem_En`=0
  - `Mem_Write_EN` = ~Wr of the winner
  - `Mem_Addr` and `Mem_DIn` from the winner's inputs
- On leaving ACCESS: `Mem_En`=1, `Mem_Write_EN`=1. `Mem_Addr` and `Mem_DIn` hold their values.
- Read data: on the ACCESS→RESP edge, capture `Mem_DOut` into the granted port's `RData` (reads only). A write leaves `RData` unchanged, and the other port's `RData` never changes.
- `Ack` of the granted port is high for the whole RESP cycle only. The other port's Ack stays 0.
- The RESP→IDLE edge never samples Req. The requester sees Ack at that edge and may drop Req or present a new request.
- Reset values: state IDLE, `Mem_En`=1, `Mem_Write_EN`=1, `Mem_Addr`=0, `Mem_DIn`=0, `Ack0`/`Ack1`=0, `RData0`/`RData1`=0, `Busy`=0, `last`=1, lock cleared.

## Timing
- Request latency:
  - Req is high at posedge T0 in IDLE.
  - Memory is enabled in cycle T0–T1, and the memory acts at the negedge inside it.
  - Read data is captured at T1.
  - Ack is high in cycle T1–T2.
  - Next arbitration is at T3.
- Throughput: one access per 3 cycles. A waiting port is served within 6 cycles when no lock is active.
- `Mem_En` is low for exactly one cycle per access. The memory therefore sees exactly one enabled negedge, with Address, DIn and Write_EN stable across it (they change only on posedges).
- Asynchronous reset during ACCESS forces `Mem_En` high immediately. If reset arrives before the negedge, the write is suppressed. If reset arrives during RESP, the Ack is cut short and the transaction is treated as lost.
- Req dropped before Ack (protocol violation): the transaction already in flight still completes and acks. A request seen in IDLE with Req low is ignored.

## Structure
- Package `mem_arbiter_pkg`:
  - State encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Port IDs: PORT0=1'b0, PORT1=1'b1.
  - Default widths.
- One natural sub-module, `rr_pick2`: combinational winner selection from Req0, Req1, `last` and the lock state. It outputs `grant_valid` and `grant_id`.
- The FSM and output registers live in `mem_arbiter`.

## Test plan
- Single read: memory preloaded with `mem[0x05]`=0xBEEF. Req0 read of 0x05 → `Mem_En` low for exactly 1 cycle, `Ack0` 2 cycles after the request edge, `RData0`=0xBEEF, `RData1`=0.
- Write then read on port 1: write 0x1234 to 0x80, then read 0x80 → `Mem_Write_EN` low only in the write's ACCESS cycle, `RData1`=0x1234 after the second Ack.
- Contention: Req0 and Req1 both held high for 4 transactions each → grants alternate 0,1,0,1…, port 0 first after reset, and no Ack overlaps.
- Lock: Lock1 high across 2 transactions with Req0 pending → port 1 is granted twice in a row. After Lock1 drops, port 0 gets the next grant.
- Reset mid-write: assert Reset after the posedge entering ACCESS but before the negedge → `mem[addr]` unchanged, all outputs at reset values, no Ack.
- Req/Ack protocol: Req0 held high through RESP → exactly one Ack per transaction. A back-to-back request is re-granted at T3, not at T2.
